// File: rtl/corescore_collector_uart.sv
// 8N1 UART receiver: oversamples the RX pin, samples each bit at mid-period and
// delivers bytes on a valid/ready stream with framing-error and overrun pulses.
module corescore_collector_uart #(
    parameter int unsigned clk_freq_hz = 0,
    parameter int unsigned baud_rate   = 57600
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int unsigned Full = clk_freq_hz / baud_rate;
    localparam int unsigned Half = Full / 2;
    localparam int unsigned CntW = $clog2(Full) + 1;
    localparam logic [CntW-1:0] FullM1 = CntW'(Full - 1);
    localparam logic [CntW-1:0] HalfM1 = CntW'(Half - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            deliver;
    logic            rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sync_q  <= 2'b11;
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_uart_rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        deliver = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = HalfM1;
                end
            end
            StStart: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        state_d = StData;
                        cnt_d   = FullM1;
                        idx_d   = '0;
                    end else begin
                        // Start bit gone by mid-bit: treat as a line glitch.
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = FullM1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StBreak: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output holding register: a stalled consumer keeps the old byte, the new one is dropped.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (deliver) begin
            if (valid_q && !i_ready) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_corescore_collector_uart.sv
// Scoreboard bench for corescore_collector_uart: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every accepted byte.
module tb_corescore_collector_uart;

    localparam int unsigned ClkHz = 1_600_000;
    localparam int unsigned Baud  = 100_000;
    localparam int unsigned Bit   = 16;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_uart_rx = 1'b1;
    logic       i_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;

    corescore_collector_uart #(
        .clk_freq_hz(ClkHz),
        .baud_rate  (Baud)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_uart_rx  (i_uart_rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         first_valid_cyc = -1;
    logic       valid_prev = 1'b0;
    logic [7:0] exp_q[$];

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // Monitor: bytes are checked at the moment the consumer accepts them.
    initial forever begin
        logic [7:0] exp_b;
        @(negedge i_clk);
        if (i_rst) begin
            if (o_frame_err) ferr_cnt++;
            if (o_overrun) ovr_cnt++;
            if (o_valid && !valid_prev && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (o_valid && i_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%02h, required no delivery", o_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (o_data !== exp_b) begin
                        n_fail++;
                        $display("FAIL rx_byte: got 0x%02h, required 0x%02h", o_data, exp_b);
                    end
                end
            end
        end
        valid_prev = o_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        i_uart_rx = b;
        tick(Bit);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int f0;
        int o0;
        int t_fall;

        // Reset with idle line.
        tick(4);
        chk("rst_data", o_data, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_ferr", o_frame_err, 0);
        chk("rst_ovr", o_overrun, 0);
        i_rst = 1'b1;
        tick(30);
        chk("idle_valid", o_valid, 0);

        // Single byte, consumer always ready.
        i_ready = 1'b1;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        first_valid_cyc = -1;
        exp_q.push_back(8'hA5);
        t_fall = cyc;
        send_frame(8'hA5, 1'b1);
        tick(10);
        wait_drain("a5_drain", 50);
        chk("a5_latency_ok", (first_valid_cyc - t_fall >= 150) && (first_valid_cyc - t_fall <= 160), 1);
        chk("a5_ferr", ferr_cnt - f0, 0);
        chk("a5_ovr", ovr_cnt - o0, 0);

        // Back-to-back with a stalled consumer: first byte held, two overruns.
        i_ready = 1'b0;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        tick(4);
        chk("b2b_valid", o_valid, 1);
        chk("b2b_data", o_data, 8'h3C);
        chk("b2b_ovr", ovr_cnt - o0, 2);
        chk("b2b_ferr", ferr_cnt - f0, 0);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        tick(2);
        chk("b2b_valid_after", o_valid, 0);
        wait_drain("b2b_drain", 5);

        // Framing error held as a long break, then a clean frame.
        i_ready = 1'b1;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send_frame(8'h55, 1'b0);
        tick(40);
        i_uart_rx = 1'b1;
        tick(20);
        chk("ferr_count", ferr_cnt - f0, 1);
        chk("ferr_valid", o_valid, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        tick(10);
        wait_drain("after_ferr_drain", 50);
        chk("after_ferr_ovr", ovr_cnt - o0, 0);

        // Short low glitch on an idle line.
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        i_uart_rx = 1'b0;
        tick(4);
        i_uart_rx = 1'b1;
        tick(40);
        chk("glitch_valid", o_valid, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_ovr", ovr_cnt - o0, 0);

        // Reset part-way through a frame; only the following byte arrives.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        i_rst = 1'b0;
        i_uart_rx = 1'b1;
        tick(3);
        chk("midrst_valid", o_valid, 0);
        i_rst = 1'b1;
        tick(20);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        tick(10);
        wait_drain("midrst_drain", 50);
        chk("midrst_ferr", ferr_cnt - f0, 0);
        chk("midrst_ovr", ovr_cnt - o0, 0);

        tick(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
